kyber_red_sched: RTL
====================

# kyber_red_sched

Scheduler that shares one Kyber reduction pipeline (fixed latency, no stall) between two requesters. It arbitrates round-robin on each issue cycle and drives the pipeline's start/operand inputs from a registered issue stage. A tag pipeline returns each result to the requester that issued it. It owns the pipeline's modulus register and applies modulus updates only after the pipeline has drained.

## Interface
- DATA_W, 24, operand/result width
- MOD_W, 12, modulus width
- LAT, 4, pipeline latency: cycles from red_start_o high to red_valid_i high
- MOD_RST, 3329, modulus register reset value
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req0_valid_i / req1_valid_i  in  1  requester N has an operand
- req0_x_i / req1_x_i  in  DATA_W  operand
- req0_ready_o / req1_ready_o  out  1  operand accepted this cycle (valid & ready)
- rsp0_valid_o / rsp1_valid_o  out  1  result for requester N; single-cycle pulse, no backpressure
- rsp_data_o  out  DATA_W  result, shared by both response ports
- cfg_valid_i  in  1  modulus update request; held with cfg_m_i until acknowledged
- cfg_m_i  in  MOD_W  new modulus
- cfg_ready_o  out  1  update applied at the end of this cycle
- red_start_o  out  1  pipeline start
- red_x_o  out  DATA_W  pipeline operand
- red_m_o  out  MOD_W  pipeline modulus (m_q)
- red_result_i  in  DATA_W  pipeline result
- red_valid_i  in  1  pipeline result valid
- busy_o  out  1  in-flight count nonzero, or issue stage full

## Operation
- FSM states: RUN (reset state), DRAIN, LOAD.
- RUN:
  - If cfg_valid_i=1: no grant this cycle; next state is DRAIN.
  - Otherwise grant one requester:
    - Only one valid: grant it.
    - Both valid: grant rr_q.
    - After any grant to requester i, rr_q <= ~i. rr_q resets to 0.
- DRAIN: no grants. Go to LOAD when in_flight==0, the issue stage is empty, and red_valid_i=0.
- LOAD: cfg_ready_o=1; m_q <= cfg_m_i at the clock edge; next state is RUN. No grants in LOAD.
- Issue stage: on a grant, red_start_o<=1, red_x_o<=granted x, tag_q<=granted id (registered). With no grant, red_start_o<=0 and red_x_o holds its value.
- Tag pipe: LAT-deep shift register of {valid, id}, fed from the issue stage and shifting every cycle.
  - Output aligns with red_valid_i.
  - rspN_valid_o = red_valid_i & tag_out.id==N.
  - rsp_data_o = red_result_i (combinational).
- in_flight counter (width clog2(LAT+2)):
  - +1 on red_start_o; -1 on red_valid_i.
  - Both in the same cycle: unchanged.
  - Never exceeds LAT+1.
- Widths: operands pass unmodified; the block does no arithmetic on data.

## Timing
- Reset values: req*_ready_o=0, rsp*_valid_o=0, rsp_data_o=0 (pipeline reset), cfg_ready_o=0, red_start_o=0, red_x_o=0, red_m_o=MOD_RST, busy_o=0, state=RUN, rr_q=0, in_flight=0, tag pipe cleared.
- req*_ready_o is combinational from the valids, cfg_valid_i, state and rr_q; at most one is high per cycle.
- Throughput is one issue per cycle, sustained.
- Accept at cycle T: red_start_o high at T+1; response pulse at T+1+LAT (T+5 at default).
- Ordering: responses return in issue order; no reordering.
- Config latency:
  - cfg_valid_i rising at T with the pipeline idle: DRAIN at T+1, LOAD at T+2, cfg_ready_o high at T+2, red_m_o new at T+3.
  - Pipeline busy: LOAD follows the last red_valid_i by one cycle.
  - In-flight operations complete with the old modulus.
- Simultaneous cfg_valid_i and request valids in RUN: cfg wins; requests stall (ready=0).
- Reset mid-operation: everything returns to reset values. In-flight results are discarded and no rsp pulse follows.
- A red_valid_i with tag_out.valid=0 is a protocol error. The scheduler raises no response for it; SVA asserts on it.

## Test plan
- Single request: req0_x=5000 at T, m=3329 → red_start_o at T+1; rsp0_valid_o pulse at T+5 with rsp_data_o=1671; rsp1_valid_o stays 0.
- Both requesters continuously valid for 8 cycles → grants alternate 0,1,0,1…; responses alternate rsp0/rsp1, one per cycle from T+5; busy_o=1 throughout, and 0 one cycle after the last response.
- req1 alone for 3 cycles, then both valid → req0 is granted first (rr_q=0 after the req1 grants), then alternation.
- cfg_valid_i=1, cfg_m_i=17 raised while 4 operations are in flight → no grants, the 4 responses return with m=3329, cfg_ready_o pulses, red_m_o=17. The next req0_x=40 returns rsp_data_o=6 (expected value from the reduction model at m=17).
- rst_ni pulled low 2 cycles after an accept → all outputs at reset values immediately; no rsp pulse afterwards; red_m_o=3329.
- Random valids on both ports for 10k cycles with random cfg updates → every accepted operand gets exactly one response on the correct port, in order, matching the golden mod-reduction model; the in_flight-never-exceeds-LAT+1 assertion holds.

Source files
------------

// File: rtl/kyber_red_sched.sv
// kyber_red_sched
//   Shares one fixed-latency, non-stalling Kyber reduction pipeline between two
//   requesters. A round-robin arbiter grants at most one operand per cycle into
//   a registered issue stage that drives the pipeline. A tag pipe of the same
//   depth as the pipeline returns each result to the requester that issued it.
//   The block owns the pipeline modulus and swaps it only after the pipeline has
//   fully drained, so in-flight operations always finish with the old modulus.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   reqN_valid_i, reqN_x_i   operand offer from requester N (N = 0, 1)
//   reqN_ready_o             operand accepted this cycle (combinational)
//   rspN_valid_o             single-cycle result pulse for requester N
//   rsp_data_o               result, shared by both response ports
//   cfg_valid_i, cfg_m_i     modulus update, held until cfg_ready_o
//   cfg_ready_o              update applied at the end of this cycle
//   red_start_o, red_x_o     pipeline start strobe and operand (registered)
//   red_m_o                  pipeline modulus
//   red_result_i, red_valid_i pipeline result, LAT cycles after red_start_o
//   busy_o                   work in flight or sitting in the issue stage
module kyber_red_sched #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned MOD_W   = 12,
  parameter int unsigned LAT     = 4,
  parameter int unsigned MOD_RST = 3329
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_x_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_x_i,
  output logic              req1_ready_o,
  output logic              rsp0_valid_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  input  logic              cfg_valid_i,
  input  logic [MOD_W-1:0]  cfg_m_i,
  output logic              cfg_ready_o,
  output logic              red_start_o,
  output logic [DATA_W-1:0] red_x_o,
  output logic [MOD_W-1:0]  red_m_o,
  input  logic [DATA_W-1:0] red_result_i,
  input  logic              red_valid_i,
  output logic              busy_o
);

  // Holds 0..LAT+1: LAT operations inside the pipeline plus one being issued.
  localparam int unsigned CNT_W = $clog2(LAT + 2);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOAD
  } state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  state_e                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic [MOD_W-1:0]       m_q, m_d;
  logic                   red_start_q, red_start_d;
  logic [DATA_W-1:0]      red_x_q, red_x_d;
  logic                   tag_q, tag_d;
  tag_t [LAT-1:0]         tag_pipe_q, tag_pipe_d;
  logic [CNT_W-1:0]       in_flight_q, in_flight_d;

  logic                   grant0, grant1, cfg_ready;
  tag_t                   tag_out;

  // Arbitration and configuration FSM.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    m_d       = m_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    cfg_ready = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A pending update blocks new grants so the pipeline can empty.
        if (cfg_valid_i) begin
          state_d = ST_DRAIN;
        end else begin
          // rr_q names the requester that wins a tie.
          grant0 = req0_valid_i & (~req1_valid_i | ~rr_q);
          grant1 = req1_valid_i & (~req0_valid_i |  rr_q);
        end
      end
      ST_DRAIN: begin
        // The issue stage and the result bus must also be empty: an op in
        // the issue stage is not yet counted, and the last result still
        // needs the old modulus in flight this cycle.
        if (in_flight_q == '0 && !red_start_q && !red_valid_i) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        m_d       = cfg_m_i;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (grant0) begin
      rr_d = 1'b1;
    end else if (grant1) begin
      rr_d = 1'b0;
    end
  end

  // Issue stage, tag pipe and in-flight bookkeeping.
  always_comb begin
    red_start_d = grant0 | grant1;
    red_x_d     = red_x_q;
    tag_d       = tag_q;
    if (grant0) begin
      red_x_d = req0_x_i;
      tag_d   = 1'b0;
    end else if (grant1) begin
      red_x_d = req1_x_i;
      tag_d   = 1'b1;
    end

    // Stage 0 captures the issue stage, so the last stage lines up with the
    // pipeline result LAT cycles after red_start_o.
    tag_pipe_d          = tag_pipe_q;
    tag_pipe_d[0].valid = red_start_q;
    tag_pipe_d[0].id    = tag_q;
    for (int i = 1; i < int'(LAT); i++) begin
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end

    in_flight_d = in_flight_q;
    if (red_start_q && !red_valid_i) begin
      in_flight_d = in_flight_q + CNT_W'(1);
    end else if (!red_start_q && red_valid_i && in_flight_q != '0) begin
      in_flight_d = in_flight_q - CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      rr_q        <= 1'b0;
      m_q         <= MOD_W'(MOD_RST);
      red_start_q <= 1'b0;
      red_x_q     <= '0;
      tag_q       <= 1'b0;
      // NOTE: the tag pipe is reset, unlike a plain data delay line, because
      // a stale valid bit would emit a response for a discarded operation.
      tag_pipe_q  <= '0;
      in_flight_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      m_q         <= m_d;
      red_start_q <= red_start_d;
      red_x_q     <= red_x_d;
      tag_q       <= tag_d;
      tag_pipe_q  <= tag_pipe_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign tag_out      = tag_pipe_q[LAT-1];

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign cfg_ready_o  = cfg_ready;
  assign red_start_o  = red_start_q;
  assign red_x_o      = red_x_q;
  assign red_m_o      = m_q;
  assign busy_o       = (in_flight_q != '0) | red_start_q;

  // A result with no matching tag is dropped rather than misrouted.
  assign rsp0_valid_o = red_valid_i & tag_out.valid & ~tag_out.id;
  assign rsp1_valid_o = red_valid_i & tag_out.valid &  tag_out.id;
  assign rsp_data_o   = red_result_i;

  a_in_flight_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    in_flight_q <= CNT_W'(LAT + 1));

  a_orphan_result: assert property (@(posedge clk_i) disable iff (!rst_ni)
    red_valid_i |-> tag_out.valid);

endmodule
